// File: rtl/mdr_pkg.sv
// Shared types and defaults for the Memory Data Register stage.
package mdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdrState_t;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned TIMEOUT_DEF = 16;

endpackage

// File: rtl/mdr_watchdog.sv
// Wait-cycle counter for memory transactions; expired flags TIMEOUT-1 reached.
module mdr_watchdog
  import mdr_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LastCount);

endmodule

// File: rtl/mdr_unit.sv
// Memory Data Register: bus load, memory read/write handshake, status to control.
// Optional ack timeout with sticky err is enabled by defining MDR_TIMEOUT_EN.
module mdr_unit
  import mdr_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] mar_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : gBadTimeout
    $error("mdr_unit: TIMEOUT must be within 2..255");
  end

  mdrState_t         state, nextState;
  logic [DATA_W-1:0] mdrReg;
  logic [ADDR_W-1:0] addrReg;
  logic              doneReg;
  logic              inWait;
  logic              accept;
  logic              timeout;

  assign inWait = (state != IDLE);
  assign accept = (state == IDLE) && (read || write);

`ifdef MDR_TIMEOUT_EN
  logic expired;
  logic errReg;

  mdr_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clock  (clock),
    .clear  (clear),
    .start  (accept),
    .run    (inWait && !mem_ack),
    .expired(expired)
  );

  // Ack in the expiry cycle still completes the transaction.
  assign timeout = inWait && !mem_ack && expired;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      errReg <= 1'b0;
    end else if (accept) begin
      errReg <= 1'b0;
    end else if (timeout) begin
      errReg <= 1'b1;
    end
  end

  assign err = errReg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (read) begin
          nextState = RD_WAIT;
        end else if (write) begin
          nextState = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack || timeout) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    mem_req = inWait;
    busy    = inWait;
    mem_we  = (state == WR_WAIT);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mdrReg  <= '0;
      addrReg <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= inWait && mem_ack;
      if (accept) begin
        addrReg <= mar_addr;
      end
      if (state == IDLE && !read && !write && mdr_in) begin
        mdrReg <= bus_in;
      end else if (state == RD_WAIT && mem_ack) begin
        mdrReg <= mem_rdata;
      end
    end
  end

  assign mdr_out   = mdrReg;
  assign mem_wdata = mdrReg;
  assign mem_addr  = addrReg;
  assign done      = doneReg;

endmodule

// File: tb/tb_mdr_unit.sv
// Scoreboard bench for mdr_unit; timeout scenario runs when MDR_TIMEOUT_EN is defined.
module tb_mdr_unit;

  logic        clock;
  logic        clear;
  logic [31:0] bus_in;
  logic        mdr_in;
  logic        read;
  logic        write;
  logic [8:0]  mar_addr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] mdr_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  mdr_unit #(
    .DATA_W (32),
    .ADDR_W (9),
    .TIMEOUT(16)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .bus_in   (bus_in),
    .mdr_in   (mdr_in),
    .read     (read),
    .write    (write),
    .mar_addr (mar_addr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mdr_out  (mdr_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (clear === 1'b1 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 mdr_out=%h expected no completion", mdr_out);
      end else begin
        chk("done_mdr_out", {32'h0, mdr_out}, {32'h0, expQ.pop_front()});
      end
    end
  end

  initial begin
    int n;
    clear = 1'b0; bus_in = '0; mdr_in = 1'b0; read = 1'b0; write = 1'b0;
    mar_addr = '0; mem_rdata = '0; mem_ack = 1'b0;
    cyc(); cyc();
    chk("rst_mdr_out", {32'h0, mdr_out}, 64'h0);
    chk("rst_req_busy_done_err_we", {60'h0, mem_req, busy, done, err}, 64'h0);
    chk("rst_mem_addr_we", {54'h0, mem_addr, mem_we}, 64'h0);
    clear = 1'b1;
    cyc();

    // bus load
    bus_in = 32'hDEADBEEF; mdr_in = 1'b1;
    cyc();
    mdr_in = 1'b0; bus_in = 32'h0;
    chk("busload_mdr_out", {32'h0, mdr_out}, 64'hDEADBEEF);
    chk("busload_no_req", {63'h0, mem_req}, 64'h0);

    // read, ack after 3 cycles
    mar_addr = 9'h055; read = 1'b1;
    expQ.push_back(32'h12345678);
    cyc();
    read = 1'b0; mar_addr = 9'h1AA;
    for (int i = 0; i < 3; i++) begin
      chk("rd_req_busy_we", {61'h0, mem_req, busy, mem_we}, 64'h6);
      chk("rd_mem_addr", {55'h0, mem_addr}, 64'h055);
      chk("rd_no_done", {63'h0, done}, 64'h0);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
      end
      cyc();
    end
    mem_ack = 1'b0; mem_rdata = 32'hFFFF0000;
    chk("rd_done", {63'h0, done}, 64'h1);
    chk("rd_idle", {62'h0, mem_req, busy}, 64'h0);
    cyc();
    chk("rd_done_one_cycle", {63'h0, done}, 64'h0);
    chk("rd_mdr_kept", {32'h0, mdr_out}, 64'h12345678);

    // write with conflicting mdr_in
    bus_in = 32'hA5A5A5A5; mdr_in = 1'b1;
    cyc();
    bus_in = 32'h0; write = 1'b1; mar_addr = 9'h100;
    expQ.push_back(32'hA5A5A5A5);
    cyc();
    write = 1'b0; bus_in = 32'h11111111;
    chk("wr_we_req", {62'h0, mem_we, mem_req}, 64'h3);
    chk("wr_wdata", {32'h0, mem_wdata}, 64'hA5A5A5A5);
    chk("wr_mem_addr", {55'h0, mem_addr}, 64'h100);
    cyc();
    mdr_in = 1'b0;
    chk("wr_mdr_in_ignored", {32'h0, mdr_out}, 64'hA5A5A5A5);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    cyc();
    mem_ack = 1'b0;
    chk("wr_done", {63'h0, done}, 64'h1);
    cyc();
    chk("wr_mdr_unchanged", {32'h0, mdr_out}, 64'hA5A5A5A5);

    // priority read > write, write pulse during wait ignored
    read = 1'b1; write = 1'b1; mar_addr = 9'h0AB;
    expQ.push_back(32'hCAFEF00D);
    cyc();
    read = 1'b0; write = 1'b0;
    chk("prio_we_read", {62'h0, mem_we, mem_req}, 64'h1);
    write = 1'b1; mar_addr = 9'h0CC;
    cyc();
    write = 1'b0;
    chk("prio_wait_we", {62'h0, mem_we, mem_req}, 64'h1);
    chk("prio_addr_held", {55'h0, mem_addr}, 64'h0AB);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    cyc();
    mem_ack = 1'b0;
    chk("prio_done", {63'h0, done}, 64'h1);
    // back-to-back: issue a read while done is high
    read = 1'b1; mar_addr = 9'h077;
    expQ.push_back(32'h0BADF00D);
    cyc();
    read = 1'b0;
    chk("b2b_req_addr", {54'h0, mem_req, mem_addr}, {54'h0, 1'b1, 9'h077});
    chk("b2b_no_second_done", {63'h0, done}, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    cyc();
    mem_ack = 1'b0;
    cyc();

    // ack while idle ignored
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    cyc();
    mem_ack = 1'b0;
    chk("idle_ack_no_done", {62'h0, done, mem_req}, 64'h0);
    chk("idle_ack_mdr", {32'h0, mdr_out}, 64'h0BADF00D);

    // reset mid RD_WAIT
    read = 1'b1; mar_addr = 9'h033;
    cyc();
    read = 1'b0;
    cyc();
    #2 clear = 1'b0;
    #1;
    chk("midrst_req", {63'h0, mem_req}, 64'h0);
    chk("midrst_mdr_out", {32'h0, mdr_out}, 64'h0);
    cyc();
    clear = 1'b1;
    cyc();
    chk("postrst_busy_done_err", {61'h0, busy, done, err}, 64'h0);

`ifdef MDR_TIMEOUT_EN
    bus_in = 32'h5555AAAA; mdr_in = 1'b1;
    cyc();
    mdr_in = 1'b0;
    read = 1'b1; mar_addr = 9'h044;
    cyc();
    read = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    chk("to_req_cycles", 64'(n), 64'd16);
    chk("to_err", {63'h0, err}, 64'h1);
    chk("to_mdr_unchanged", {32'h0, mdr_out}, 64'h5555AAAA);
    cyc();
    chk("to_err_sticky", {63'h0, err}, 64'h1);
    read = 1'b1; mar_addr = 9'h045;
    expQ.push_back(32'h77778888);
    cyc();
    read = 1'b0;
    chk("to_err_cleared", {63'h0, err}, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h77778888;
    cyc();
    mem_ack = 1'b0;
    cyc();
`else
    n = 0;
    chk("no_timeout_err", {63'h0, err}, 64'h0);
`endif

    cyc();
    chk("all_done_seen", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
